// File: rtl/osd_dem_uart_pkg.sv
// Shared definitions for the UART character-stream DEM arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package osd_dem_uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/osd_rr_pick.sv
// Round-robin picker: first set request searching upward from (last+1) mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the winner is consumed.
module osd_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner
);

    logic         w_found;
    logic [W-1:0] w_idx;

    // Scan the N candidates in priority order starting just after last.
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = W'((int'(last) + i) % N);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_dem_uart_arbiter.sv
// Line-granular round-robin merge of N UART character sources onto one stream.
// Latency: 1 cycle to grant from IDLE; characters pass through combinationally once locked.
// Backpressure: out_ready goes straight to the granted source; a stalled sink never times out the lock.
module osd_dem_uart_arbiter
    import osd_dem_uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req_valid,
    input  logic [8*N-1:0]                       req_char,
    output logic [N-1:0]                         req_ready,
    output logic                                 out_valid,
    output logic [7:0]                           out_char,
    input  logic                                 out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_src
);

    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    r_state;
    logic [W-1:0]  r_grant;
    logic [W-1:0]  r_last;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  w_winner;
    logic          w_locked;
    logic          w_src_vld;
    logic [7:0]    w_src_char;
    logic          w_xfer;
    logic          w_is_lf;
    logic          w_expired;

    osd_rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req    (req_valid),
        .last   (r_last),
        .winner (w_winner)
    );

    // Reset masks the lock immediately so nothing transfers in the reset cycle.
    assign w_locked   = (r_state == ST_LOCKED) && !rst;
    assign w_src_vld  = req_valid[r_grant];
    assign w_src_char = req_char[{r_grant, 3'b000} +: 8];
    assign w_xfer     = w_locked && w_src_vld && out_ready;
    assign w_is_lf    = (w_src_char == ASCII_LF);
    assign w_expired  = (r_cnt == CW'(TIMEOUT));

    assign out_valid  = w_locked && w_src_vld;
    assign out_char   = w_src_char;
    assign out_src    = rst ? '0 : r_grant;

    // Only the granted source sees the downstream ready; everyone else holds.
    always_comb begin
        req_ready = '0;
        if (w_locked) begin
            req_ready[r_grant] = out_ready;
        end
    end

    // Grant/lock FSM with the idle-timeout counter; LF or timeout releases the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= W'(N - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_winner;
                        r_state <= ST_LOCKED;
                        r_cnt   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer && w_is_lf) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_grant;
                        r_cnt   <= '0;
                    end else if (w_xfer) begin
                        r_cnt   <= '0;
                    end else if (w_expired) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_grant;
                        r_cnt   <= '0;
                    end else if (!w_src_vld) begin
                        // Back-pressured characters do not count as idle.
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_dem_uart_arbiter.sv
// Self-checking bench: per-source line queues driven with hold semantics,
// compared cycle by cycle against a behavioural model of line-locked round-robin.
module tb_osd_dem_uart_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_char;
    logic [N-1:0] req_ready;
    logic         out_valid;
    logic [7:0]   out_char;
    logic         out_ready;
    logic [1:0]   out_src;

    always #5 clk = ~clk;

    osd_dem_uart_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_char  (req_char),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Source side: queued characters, and the one currently being offered.
    logic [7:0] srcq[N][$];
    bit         pres[N];
    logic [7:0] pres_ch[N];
    int         pres_pct = 100;
    int         rdy_pct  = 100;
    bit         do_rst   = 1'b0;
    bit         rand_rst = 1'b0;

    // Model: which source owns the line, who owned it last, idle run length.
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_last   = N - 1;
    int m_idle   = 0;

    // Accepted-character log.
    int         log_src[$];
    logic [7:0] log_ch[$];
    int         log_cyc[$];
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic load(input int s, input string str);
        for (int k = 0; k < str.len(); k++) srcq[s].push_back(str[k]);
    endtask

    task automatic clear_log();
        log_src.delete();
        log_ch.delete();
        log_cyc.delete();
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model.
    task automatic cycle();
        bit          found;
        int          w;
        logic        exp_vld;
        logic [31:0] exp_rdy;
        logic [31:0] exp_src;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && srcq[i].size() > 0 && $urandom_range(99) < pres_pct) begin
                pres[i]    = 1'b1;
                pres_ch[i] = srcq[i][0];
            end
            req_valid[i]       = pres[i];
            req_char[8*i +: 8] = pres_ch[i];
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        rst = do_rst || (rand_rst && $urandom_range(299) == 0);
        #1;
        exp_vld = !rst && m_locked && pres[m_owner];
        exp_rdy = (!rst && m_locked && out_ready) ? (32'd1 << m_owner) : 32'd0;
        exp_src = rst ? 32'd0 : 32'(m_owner);
        chk("out_valid", out_valid, exp_vld);
        chk("req_ready", req_ready, exp_rdy);
        chk("out_src", out_src, exp_src);
        if (exp_vld) chk("out_char", out_char, pres_ch[m_owner]);

        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_last   = N - 1;
            m_idle   = 0;
        end else if (!m_locked) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                w = (m_last + k) % N;
                if (!found && pres[w]) begin
                    found    = 1'b1;
                    m_owner  = w;
                    m_locked = 1'b1;
                    m_idle   = 0;
                end
            end
        end else if (pres[m_owner] && out_ready) begin
            log_src.push_back(m_owner);
            log_ch.push_back(pres_ch[m_owner]);
            log_cyc.push_back(cyc);
            void'(srcq[m_owner].pop_front());
            pres[m_owner] = 1'b0;
            if (pres_ch[m_owner] == 8'h0A) begin
                m_locked = 1'b0;
                m_last   = m_owner;
            end else begin
                m_idle = 0;
            end
        end else if (m_idle == TO) begin
            m_locked = 1'b0;
            m_last   = m_owner;
        end else if (!pres[m_owner]) begin
            m_idle++;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() || m_locked) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", {31'd0, pending() || m_locked}, 32'd0);
    endtask

    task automatic expect_log(input string tag, input string srcs, input string chars);
        chk({tag, "_len"}, log_src.size(), srcs.len());
        for (int k = 0; k < srcs.len() && k < log_src.size(); k++) begin
            chk({tag, "_src"}, log_src[k], 32'(srcs[k] - 8'd48));
            chk({tag, "_chr"}, log_ch[k], chars[k]);
        end
    endtask

    initial begin
        int c0;
        req_valid = '0;
        req_char  = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < N; i++) begin
            pres[i]    = 1'b0;
            pres_ch[i] = 8'h00;
        end

        // Reset
        do_rst = 1'b1;
        repeat (3) cycle();
        do_rst = 1'b0;
        cycle();

        // Source 2 sends "A\n": granted one cycle after valid, then two transfers.
        clear_log();
        c0 = cyc;
        load(2, "A\n");
        drain(50);
        expect_log("single", "22", "A\n");
        if (log_cyc.size() >= 2) begin
            chk("single_lat0", log_cyc[0] - c0, 1);
            chk("single_lat1", log_cyc[1] - c0, 2);
        end

        // Two sources, whole lines never interleave.
        clear_log();
        load(0, "xy\n");
        load(1, "xy\n");
        drain(100);
        expect_log("two_lines", "000111", "xy\nxy\n");

        // Timeout: 'a' then silence; lock lasts TO idle increments plus the
        // expiry cycle, then one IDLE arbitration cycle before 'z' moves.
        clear_log();
        load(3, "a");
        cycle();
        cycle();
        load(0, "z\n");
        drain(100);
        expect_log("timeout", "300", "az\n");
        if (log_cyc.size() >= 2) chk("timeout_gap", log_cyc[1] - log_cyc[0], TO + 3);

        // Long back-pressure: lock held, character stable.
        rdy_pct = 0;
        load(1, "b\n");
        repeat (1000) cycle();
        chk("bp_src", out_src, 1);
        chk("bp_vld", out_valid, 1);
        chk("bp_chr", out_char, 8'h62);
        rdy_pct = 100;
        drain(50);

        // Reset mid-line on source 2; arbitration restarts at source 0.
        load(2, "pq\n");
        cycle();
        cycle();
        load(0, "r\n");
        do_rst = 1'b1;
        cycle();
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_src", out_src, 0);
        do_rst = 1'b0;
        clear_log();
        cycle();
        chk("post_rst_vld", out_valid, 0);
        chk("post_rst_src", out_src, 0);
        drain(100);
        expect_log("rst_mid", "0022", "r\nq\n");

        // Four sources sending bare LFs: strict rotation, two cycles per line.
        do_rst = 1'b1;
        cycle();
        do_rst = 1'b0;
        clear_log();
        for (int i = 0; i < N; i++) load(i, "\n\n");
        drain(100);
        expect_log("rr", "01230123", "\n\n\n\n\n\n\n\n");
        for (int k = 1; k < log_cyc.size(); k++) chk("rr_gap", log_cyc[k] - log_cyc[k-1], 2);

        // Randomised traffic with gaps, stalls, unterminated lines and stray resets.
        rand_rst = 1'b1;
        for (int r = 0; r < 8; r++) begin
            pres_pct = $urandom_range(100, 30);
            rdy_pct  = $urandom_range(100, 30);
            for (int s = 0; s < N; s++) begin
                int nl = $urandom_range(3, 0);
                for (int l = 0; l < nl; l++) begin
                    int len = $urandom_range(5, 0);
                    for (int c = 0; c < len; c++)
                        srcq[s].push_back(8'($urandom_range(8'h7e, 8'h20)));
                    if ($urandom_range(99) < 80) srcq[s].push_back(8'h0A);
                end
            end
            drain(5000);
        end
        rand_rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
